alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - Producer side of the ALU interface: decodes MIPS instruction words into {a, b, fncode, dest} for alu.
// - Sits between register read and execute; registered output with valid/ready handshake and a 2-entry skid buffer.
// - Absorbs one cycle of execute backpressure without a combinational ready path from out_ready to in_ready.
// PARAMETERS
// - DW     32  operand/result width (fixed at 32 for MIPS; parameterised for bench reuse)
// - RW     5   register index width
// PORTS
// - clk        in   1    clock, all state on rising edge
// - reset_n    in   1    synchronous active-low reset
// - flush      in   1    synchronous pipeline kill; empties both entries
// - in_valid   in   1    instr/operands valid
// - in_ready   out  1    stage can accept this cycle (registered)
// - instr      in   32   instruction word
// - rs_val     in   DW   value of GPR[rs]
// - rt_val     in   DW   value of GPR[rt]
// - out_valid  out  1    issued op valid
// - out_ready  in   1    execute consumes op
// - a, b       out  DW   ALU operands
// - fncode     out  funct_t  ALU function
// - dest       out  RW   destination register index
// - illegal    out  1    only with ALU_ISSUE_ILLEGAL_EN; op unsupported
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): out_valid=0, in_ready=1, skid empty, a=b=0, dest=0, fncode=FUNCT_ADDU, illegal=0.
// - Transfer in: in_valid&in_ready. Transfer out: out_valid&out_ready. Latency 1 cycle, in-order, no loss/duplication.
// - Decode: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
//   op 0x00, funct 0x21/0x23/0x24/0x25/0x26 -> ADDU/SUBU/AND/OR/XOR; a=rs_val, b=rt_val, dest=rd.
//   op 0x09 ADDIU -> FUNCT_ADDU, b=sign-extended imm; op 0x0C/0x0D/0x0E ANDI/ORI/XORI -> AND/OR/XOR, b=zero-extended imm; a=rs_val, dest=rt.
//   Any other op/funct is unsupported (see CONFIGURATION). dest=0 is issued normally.
// - Storage: main output reg M, skid reg S. in_ready = !S.valid (registered).
//   M empty or being consumed: accepted op -> M. M held (out_valid&!out_ready) and op accepted: op -> S; in_ready drops next cycle.
//   M consumed while S full: S -> M, S empties, in_ready rises next cycle; no new accept that cycle (in_ready was 0).
// - flush has priority over accept/consume: next cycle out_valid=0, S empty, in_ready=1; op presented with flush is dropped.
// - Reset mid-operation: identical to flush plus output value clear; in_valid ignored during reset.
// - Outputs stable while out_valid&!out_ready (AXI-style hold).
// CONFIGURATION
// - ALU_ISSUE_ILLEGAL_EN defined: unsupported ops are issued with illegal=1, fncode=FUNCT_ADDU, a=b=0, dest=0.
// - Not defined: unsupported ops are consumed (in_ready honoured) and never issued; illegal port absent.
// STRUCTURE
// - Shared package mips_pkg: funct_t and FUNCT_* values (ADDU 6'h21, SUBU 6'h23, AND 6'h24, OR 6'h25, XOR 6'h26),
//   opcode constants OP_RTYPE/OP_ADDIU/OP_ANDI/OP_ORI/OP_XORI, issue_t struct {a,b,fncode,dest,illegal}.
// - One sub-module: alu_issue_decode (combinational instr+operands -> issue_t + supported flag); top holds M/S regs and handshake.
// TESTING
// - ADDIU 0x2508FFFF, rs_val=5, out_ready=1 -> next cycle out_valid=1, a=5, b=0xFFFFFFFF, fncode=ADDU, dest=8.
// - ORI 0x3508FFFF, rs_val=0x12340000 -> a=0x12340000, b=0x0000FFFF, fncode=OR, dest=8.
// - SUBU 0x01095023, rs_val=10, rt_val=3 -> a=10, b=3, fncode=SUBU, dest=10.
// - out_ready=0, push ops X,Y,Z back-to-back -> X in M, Y in S, in_ready=0 from cycle 2, Z held; out_ready=1 -> X,Y,Z out in order.
// - M and S full, flush=1 one cycle -> next cycle out_valid=0, in_ready=1; reset_n=0 same state plus a=b=0.
// - LW 0x8C000000: with ALU_ISSUE_ILLEGAL_EN -> issued, illegal=1, b=0; without -> in_ready pulse, out_valid stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS ALU-interface types: function codes, opcode constants and the issue record.
package mips_pkg;

  localparam int ISSUE_DW = 32;
  localparam int ISSUE_RW = 5;

  typedef enum logic [5:0] {
    FUNCT_ADDU = 6'h21,
    FUNCT_SUBU = 6'h23,
    FUNCT_AND  = 6'h24,
    FUNCT_OR   = 6'h25,
    FUNCT_XOR  = 6'h26
  } funct_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  typedef struct packed {
    logic [ISSUE_DW-1:0] a;
    logic [ISSUE_DW-1:0] b;
    funct_t              fncode;
    logic [ISSUE_RW-1:0] dest;
    logic                illegal;
  } issue_t;

  localparam issue_t ISSUE_RST = '{a: '0, b: '0, fncode: FUNCT_ADDU, dest: '0, illegal: 1'b0};

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of an instruction word plus register operands into an ALU issue record.
module alu_issue_decode
  import mips_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [ISSUE_DW-1:0] rs_val,
  input  logic [ISSUE_DW-1:0] rt_val,
  output issue_t              issue,
  output logic                supported
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign imm          = instr[15:0];
  assign unused_shamt = ^instr[10:6];

  // Unsupported ops fall through as an illegal record with zeroed operands.
  always_comb begin
    issue         = ISSUE_RST;
    issue.illegal = 1'b1;
    supported     = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_ADDU || funct == FUNCT_SUBU || funct == FUNCT_AND ||
            funct == FUNCT_OR   || funct == FUNCT_XOR) begin
          issue.fncode = funct_t'(funct);
          issue.a      = rs_val;
          issue.b      = rt_val;
          issue.dest   = instr[15:11];
          supported    = 1'b1;
        end
      end
      OP_ADDIU: begin
        issue.fncode = FUNCT_ADDU;
        issue.a      = rs_val;
        issue.b      = {{(ISSUE_DW-16){imm[15]}}, imm};
        issue.dest   = instr[20:16];
        supported    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        issue.fncode = (op == OP_ANDI) ? FUNCT_AND : (op == OP_ORI) ? FUNCT_OR : FUNCT_XOR;
        issue.a      = rs_val;
        issue.b      = {{(ISSUE_DW-16){1'b0}}, imm};
        issue.dest   = instr[20:16];
        supported    = 1'b1;
      end
      default: ;
    endcase
    if (supported) issue.illegal = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, registered output M plus skid entry S with valid/ready handshake.
// Define ALU_ISSUE_ILLEGAL_EN to issue unsupported ops flagged on the illegal port instead of dropping them.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic          illegal,
`endif
  output logic [5:0]    fncode,
  output logic [RW-1:0] dest
);

  issue_t dec_issue;
  logic   dec_supported;
  issue_t m_q, m_d, s_q, s_d;
  logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic   accept, store, consume;

  alu_issue_decode u_decode (
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .issue     (dec_issue),
    .supported (dec_supported)
  );

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign consume  = m_valid_q && out_ready;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic unused_supported;
  assign unused_supported = dec_supported;
  assign store   = accept;
  assign illegal = m_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = m_q.illegal ^ s_q.illegal;
  assign store = accept && dec_supported;
`endif

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || consume) begin
      // S always drains before a new op; in_ready was low whenever S held data.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (store) begin
        m_d       = dec_issue;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (store) begin
      s_d       = dec_issue;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_q       <= ISSUE_RST;
      s_q       <= ISSUE_RST;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid = m_valid_q;
  assign a         = m_q.a;
  assign b         = m_q.b;
  assign fncode    = m_q.fncode;
  assign dest      = m_q.dest;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases plus randomized traffic against a decode model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] instr, rs_val, rt_val, a, b;
  logic [5:0]  fncode;
  logic [4:0]  dest;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        illegal;
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .fncode(fncode), .dest(dest)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fn;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA table; returns whether the op reaches the output.
  function automatic bit ref_model(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt, output exp_t e);
    int op, fn;
    bit ok;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    e.a = 0; e.b = 0; e.fn = 6'h21; e.dest = 0; e.ill = 1'b1;
    ok = 1'b0;
    if (op == 0 && (fn == 'h21 || fn == 'h23 || fn == 'h24 || fn == 'h25 || fn == 'h26)) begin
      e.fn = 6'(fn); e.a = rs; e.b = rt; e.dest = ins[15:11]; ok = 1'b1;
    end else if (op == 'h09) begin
      e.a = rs; e.b = 32'($signed(ins[15:0])); e.dest = ins[20:16]; ok = 1'b1;
    end else if (op == 'h0C || op == 'h0D || op == 'h0E) begin
      e.fn = (op == 'h0C) ? 6'h24 : (op == 'h0D) ? 6'h25 : 6'h26;
      e.a = rs; e.b = 32'(ins[15:0]); e.dest = ins[20:16]; ok = 1'b1;
    end
    if (ok) e.ill = 1'b0;
    return ok || ILL_EN;
  endfunction

  // Monitor: state is checked at the falling edge, then the coming rising edge is modelled.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   rdy_exp;
      exp_t e;
      rdy_exp = (q.size() < 2);
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(rdy_exp));
      if (out_valid && q.size() > 0) begin
        chk("a", a, q[0].a);
        chk("b", b, q[0].b);
        chk("fncode", 32'(fncode), 32'(q[0].fn));
        chk("dest", 32'(dest), 32'(q[0].dest));
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("illegal", 32'(illegal), 32'(q[0].ill));
`endif
      end
      if (!reset_n || flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && rdy_exp && ref_model(instr, rs_val, rt_val, e)) q.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bit acc;
    int n;
    instr = ins; rs_val = rs; rt_val = rt; in_valid = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      cyc();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  op, fn;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: op = 6'h00; 1: op = 6'h09; 2: op = 6'h0C; 3: op = 6'h0D;
      4: op = 6'h0E; 5: op = 6'h23; default: op = 6'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: fn = 6'h21; 1: fn = 6'h23; 2: fn = 6'h24; 3: fn = 6'h25;
      4: fn = 6'h26; default: fn = 6'($urandom);
    endcase
    return {op, r[25:6], fn};
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_a"}, a, 32'd0);
    chk({tag, "_b"}, b, 32'd0);
    chk({tag, "_dest"}, 32'(dest), 32'd0);
    chk({tag, "_fncode"}, 32'(fncode), 32'h21);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; rs_val = 32'h0; rt_val = 32'h0;
    repeat (3) cyc();
    check_reset_state("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    send(32'h2508FFFF, 32'd5, 32'd0);
    send(32'h3508FFFF, 32'h12340000, 32'd0);
    send(32'h01095023, 32'd10, 32'd3);
    repeat (3) cyc();

    // X to M, Y to skid, Z held while in_ready is low
    out_ready = 1'b0;
    send(32'h01095021, 32'h11, 32'h22);
    send(32'h01095024, 32'h33, 32'h44);
    instr = 32'h01095026; rs_val = 32'h55; rt_val = 32'h66; in_valid = 1'b1;
    repeat (3) cyc();
    chk("skid_full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(32'h01095026, 32'h55, 32'h66);
    repeat (4) cyc();

    out_ready = 1'b0;
    send(32'h2508FFFF, 32'd7, 32'd0);
    send(32'h3508FFFF, 32'd9, 32'd0);
    instr = 32'h01095023; in_valid = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    send(32'h2508FFFF, 32'd7, 32'd0);
    send(32'h3508FFFF, 32'd9, 32'd0);
    instr = 32'h01095023; in_valid = 1'b1; reset_n = 1'b0;
    cyc();
    reset_n = 1'b1; in_valid = 1'b0;
    check_reset_state("midreset");
    out_ready = 1'b1;

    send(32'h8C000000, 32'h1234, 32'h5678);
    repeat (3) cyc();

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      instr     = rand_instr();
      rs_val    = $urandom;
      rt_val    = $urandom;
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    chk("drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
